// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding, tap function and defaults for the LFSR generator/checker pair
package lfsr_pkg;
  localparam int DEF_NUM_LEN = 10;
  localparam int LFSR_MAX_LEN = 64;
  typedef enum logic [1:0] {FILL, SYNC, LOCKED} state_t;
  function automatic logic tap(input logic [LFSR_MAX_LEN-1:0] h, input int n);
    return h[n-1] ^ h[n-2];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over increment; increment stops at all-ones
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising Fibonacci LFSR stream checker; LFSR_CHECKER_BITCNT_EN adds bit_cnt
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_LEN  = DEF_NUM_LEN,
  parameter int SYNC_CNT = 16,
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
`ifdef LFSR_CHECKER_BITCNT_EN
  ,
  output logic [ERR_W-1:0] bit_cnt
`endif
);
  localparam int FW = $clog2(NUM_LEN + 1);
  localparam int MW = $clog2(SYNC_CNT + 1);
  localparam int LW = $clog2(LOSS_THR + 1);
  state_t state_q, state_d;
  logic [NUM_LEN-1:0] h_q, h_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic locked_q, err_q, err_d;
  logic p;
  assign p = tap(LFSR_MAX_LEN'(h_q), NUM_LEN);
  // acquisition and tracking: fill history, count clean predictions, then free-run and count misses
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    fill_d = fill_q;
    match_d = match_q;
    miss_d = miss_q;
    err_d = 1'b0;
    if (en) begin
      unique case (state_q)
        FILL: begin
          h_d = {h_q[NUM_LEN-2:0], din};
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(NUM_LEN - 1)) begin
            state_d = SYNC;
            fill_d = '0;
          end
        end
        SYNC: begin
          h_d = {h_q[NUM_LEN-2:0], din};
          match_d = (din == p && |h_q) ? match_q + 1'b1 : '0;
          if (din == p && |h_q && match_q == MW'(SYNC_CNT - 1)) begin
            state_d = LOCKED;
            match_d = '0;
          end
        end
        LOCKED: begin
          h_d = {h_q[NUM_LEN-2:0], p};
          err_d = din != p;
          miss_d = err_d ? miss_q + 1'b1 : '0;
          if (err_d && miss_q == LW'(LOSS_THR - 1)) begin
            state_d = FILL;
            miss_d = '0;
            fill_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      h_q <= '0;
      fill_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      fill_q <= fill_d;
      match_q <= match_d;
      miss_q <= miss_d;
      locked_q <= state_d == LOCKED;
      err_q <= err_d;
    end
  assign locked = locked_q;
  assign err = err_q;
  sat_counter #(.W(ERR_W)) u_err_cnt (.clk, .rst_n, .inc(err_d), .clr, .cnt(err_cnt));
`ifdef LFSR_CHECKER_BITCNT_EN
  sat_counter #(.W(ERR_W)) u_bit_cnt (.clk, .rst_n, .inc(en && state_q == LOCKED), .clr, .cnt(bit_cnt));
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed and randomized checks of lfsr_checker against a queue-based reference
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic rst_n, en, din, clr, locked, err;
  logic [1:0] err_cnt;
`ifdef LFSR_CHECKER_BITCNT_EN
  logic [1:0] bit_cnt;
`endif
  int vectors = 0, miscompares = 0;
  bit seq[15] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
  int gi = 0;
  bit hist[$];
  int m_mode, m_run, m_miss, m_cnt;
  bit m_locked, m_err;

  lfsr_checker #(.NUM_LEN(4), .SYNC_CNT(8), .LOSS_THR(3), .ERR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt)
`ifdef LFSR_CHECKER_BITCNT_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = '{0, 0, 0, 0};
    m_mode = 0; m_run = 0; m_miss = 0; m_cnt = 0;
    m_locked = 0; m_err = 0;
  endtask

  task automatic model(bit e, bit d, bit c);
    int n = hist.size();
    bit pr, nz, inc;
    pr = hist[n-4] ^ hist[n-3];
    nz = hist[n-1] | hist[n-2] | hist[n-3] | hist[n-4];
    inc = 0;
    if (e) begin
      if (m_mode == 0) begin
        hist.push_back(d);
        m_run++;
        if (m_run == 4) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        hist.push_back(d);
        m_run = (d == pr && nz) ? m_run + 1 : 0;
        if (m_run == 8) begin m_mode = 2; m_run = 0; end
      end else begin
        hist.push_back(pr);
        inc = d != pr;
        m_miss = inc ? m_miss + 1 : 0;
        if (m_miss == 3) begin m_mode = 0; m_miss = 0; m_run = 0; end
      end
      if (hist.size() > 8) void'(hist.pop_front());
    end
    m_err = inc;
    m_cnt = c ? 0 : (inc && m_cnt < 3) ? m_cnt + 1 : m_cnt;
    m_locked = m_mode == 2;
  endtask

  task automatic step(bit e, bit d, bit c);
    en = e; din = d; clr = c;
    @(posedge clk);
    model(e, d, c);
    #1;
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_cnt);
  endtask

  task automatic gen(bit e, bit flip, bit c);
    bit d;
    d = e ? seq[gi] ^ flip : bit'($urandom_range(0, 1));
    if (e) gi = (gi + 1) % 15;
    step(e, d, c);
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; din = 1'b0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    int at, pulses, lk;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_locked", locked, 0);
    chk("init_err", err, 0);
    chk("init_err_cnt", err_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    at = 0; pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      gen(1, 0, 0);
      if (locked && at == 0) at = k;
      pulses += int'(err);
    end
    chk("clean_lock_at", at, 12);
    chk("clean_err_pulses", pulses, 0);
    repeat ($urandom_range(0, 5)) gen(1, 0, 0);
    pulses = 0;
    gen(1, 1, 0);
    pulses += int'(err);
    repeat (4) begin gen(1, 0, 0); pulses += int'(err); end
    chk("iso_pulses", pulses, 1);
    chk("iso_err_cnt", err_cnt, 1);
    chk("iso_locked", locked, 1);
    gen(0, 0, 1);
    chk("clr_err_cnt", err_cnt, 0);
    repeat (3) gen(1, 1, 0);
    chk("loss_locked", locked, 0);
    chk("loss_err_cnt", err_cnt, 3);
    at = 0;
    for (int k = 1; k <= 20 && at == 0; k++) begin
      gen(1, 0, 0);
      if (locked) at = k;
    end
    chk("relock_at", at, 12);
    chk("relock_err_cnt", err_cnt, 3);
    gen(1, 1, 0);
    chk("sat_err_cnt", err_cnt, 3);
    chk("sat_err", err, 1);
    gen(1, 0, 0);
    chk("sat_locked", locked, 1);
    reset_now();
    at = 0;
    for (int k = 1; k <= 20 && at == 0; k++) begin
      gen(1, 0, 0);
      if (locked) at = k;
    end
    chk("post_rst_lock_at", at, 12);
    reset_now();
    lk = 0; pulses = 0;
    repeat (40) begin
      step(1, 0, 0);
      lk += int'(locked);
      pulses += int'(err);
    end
    chk("zero_locked", lk, 0);
    chk("zero_err", pulses, 0);
    at = 0; lk = 0;
    for (int i = 0; i < 60 && at == 0; i++) begin
      gen(i % 2 == 0, 0, 0);
      lk += (i % 2 == 0) ? 1 : 0;
      if (locked) at = lk;
    end
    chk("gap_lock_at", at, 12);
    gen(1, 1, 0);
    chk("gap_err", err, 1);
    gen(0, 0, 0);
    chk("gap_hold_err", err, 0);
    chk("gap_hold_cnt", err_cnt, 1);
    gen(1, 0, 0);
    gen(1, 1, 1);
    chk("clr_pri_err", err, 1);
    chk("clr_pri_cnt", err_cnt, 0);
    chk("clr_pri_locked", locked, 1);
    repeat (300) gen($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
